// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with valid/ready handshakes; shifts iterate one bit per cycle.
// Define ALU_ITER_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_iter_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  BrTaken,
  output logic                  Busy
);

`ifdef ALU_ITER_FAST_SHIFT_EN
  localparam bit FAST_SHIFT = 1'b1;
`else
  localparam bit FAST_SHIFT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [3:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    br_q, br_d;

  logic [SHAMT_WIDTH-1:0]  shamt;
  logic                    is_shift;
  logic                    lt_s;
  logic                    cond;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_br;
  logic [DATA_WIDTH-1:0]   acc_shifted;

  assign shamt    = SrcB[SHAMT_WIDTH-1:0];
  assign is_shift = (Operation == 4'b0110) || (Operation == 4'b0111) || (Operation == 4'b1000);
  assign lt_s     = $signed(SrcA) < $signed(SrcB);

  // Single-cycle result; in the iterative build shifts yield SrcA (the shamt==0 answer).
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    cond    = 1'b0;
    case (Operation)
      4'b0000: alu_res = SrcA + SrcB;
      4'b0001: alu_res = SrcA - SrcB;
      4'b0010: alu_res = SrcA ^ SrcB;
      4'b0011: alu_res = SrcA | SrcB;
      4'b0100: alu_res = SrcA & SrcB;
      4'b0101: alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      4'b0110: alu_res = FAST_SHIFT ? DATA_WIDTH'($signed(SrcA) >>> shamt) : SrcA;
      4'b0111: alu_res = FAST_SHIFT ? (SrcA >> shamt) : SrcA;
      4'b1000: alu_res = FAST_SHIFT ? (SrcA << shamt) : SrcA;
      4'b1010, 4'b1011, 4'b1100, 4'b1101: begin
        case (Operation)
          4'b1010: cond = (SrcA != SrcB);
          4'b1011: cond = lt_s;
          4'b1100: cond = !lt_s;
          default: cond = (SrcA == SrcB);
        endcase
        alu_res = {{(DATA_WIDTH-1){1'b0}}, cond};
        alu_br  = cond;
      end
      4'b1110: alu_res = SrcB;
      4'b1111: alu_res = SrcA + DATA_WIDTH'(4);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      4'b0110: acc_shifted = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
      4'b0111: acc_shifted = {1'b0, acc_q[DATA_WIDTH-1:1]};
      default: acc_shifted = {acc_q[DATA_WIDTH-2:0], 1'b0};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    br_d     = br_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!FAST_SHIFT && is_shift && (shamt != '0)) begin
            acc_d   = SrcA;
            cnt_d   = shamt;
            op_d    = Operation;
            state_d = SHIFT;
          end else begin
            result_d = alu_res;
            br_d     = alu_br;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - SHAMT_WIDTH'(1);
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d = acc_shifted;
          br_d     = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      br_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      br_q     <= br_d;
    end
  end

  // in_ready is gated by reset so nothing is accepted while reset is held.
  assign in_ready  = reset && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Busy      = (state_q != IDLE);
  assign ALUResult = result_q;
  assign BrTaken   = br_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed self-checking bench for alu_iter_exec: ops, branches, shifts, backpressure, reset mid-shift.
module tb_alu_iter_exec;

`ifdef ALU_ITER_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        BrTaken;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  alu_iter_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .BrTaken(BrTaken), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int shift_lat(input int k);
    return FAST ? 0 : k;
  endfunction

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_br, input int exp_lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick; n++; end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_result"}, ALUResult, exp_res);
    check({tag, "_brtaken"}, 32'(BrTaken), 32'(exp_br));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(Busy), 32'd0);
    $display("op %b A=%h B=%h -> result=%h br=%0d lat=%0d", op, a, b, ALUResult, BrTaken, n);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 4'b0; SrcA = '0; SrcB = '0;
    tick; tick;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_brtaken", 32'(BrTaken), 32'd0);
    reset = 1'b1;
    tick;

    do_op("add_wrap", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 0);
    do_op("sub",      4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 0);
    do_op("slt",      4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
    do_op("or",       4'b0011, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1'b0, 0);
    do_op("and",      4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 0);
    do_op("sra4",     4'b0110, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, shift_lat(4));
    do_op("srl4",     4'b0111, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, shift_lat(4));
    do_op("sll31",    4'b1000, 32'h1, 32'd31, 32'h8000_0000, 1'b0, shift_lat(31));
    do_op("sll0",     4'b1000, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1'b0, 0);
    do_op("sra31",    4'b0110, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, shift_lat(31));
    do_op("beq",      4'b1101, 32'd5, 32'd5, 32'd1, 1'b1, 0);
    do_op("bne",      4'b1010, 32'd5, 32'd5, 32'd0, 1'b0, 0);
    do_op("blt",      4'b1011, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b1, 0);
    do_op("bge",      4'b1100, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0, 0);
    do_op("lui",      4'b1110, 32'h55, 32'h1234_5000, 32'h1234_5000, 1'b0, 0);
    do_op("undef",    4'b1001, 32'd7, 32'd9, 32'd0, 1'b0, 0);
    do_op("jal",      4'b1111, 32'h100, 32'h0, 32'h104, 1'b0, 0);

    // Backpressure: hold out_ready low for 6 cycles while in_valid pulses.
    Operation = 4'b0010; SrcA = 32'hF0; SrcB = 32'hFF; in_valid = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0]; Operation = 4'b0000; SrcA = 32'd1; SrcB = 32'd1;
      check("hold_result", ALUResult, 32'h0000_000F);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      $display("hold cycle %0d result=%h out_valid=%0d", i, ALUResult, out_valid);
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_busy", 32'(Busy), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_result", ALUResult, 32'h0000_000F);

    // Reset asserted mid-shift (sll by 20 after 5 cycles).
    Operation = 4'b1000; SrcA = 32'h3; SrcB = 32'd20; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check("midshift_busy", 32'(Busy), FAST ? 32'd1 : 32'd1);
    check("midshift_out_valid", 32'(out_valid), FAST ? 32'd1 : 32'd0);
    reset = 1'b0;
    #1;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_busy", 32'(Busy), 32'd0);
    check("rst2_result", ALUResult, 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd0);
    $display("reset mid-shift: out_valid=%0d busy=%0d result=%h", out_valid, Busy, ALUResult);
    tick;
    reset = 1'b1;
    #1;
    check("rst2_release_in_ready", 32'(in_ready), 32'd1);
    do_op("add_after_rst", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller, plus operands from the register/immediate muxes.
- Produces a registered result and a branch-condition flag, using a valid/ready handshake on both sides.
- Non-shift ops complete in one cycle. Shifts iterate one bit per cycle, which keeps the datapath small.
- Sits between operand selection and the EX/MEM result register.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount width; shamt = SrcB[SHAMT_WIDTH-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and Operation valid.
- in_ready  output  1  unit can accept a new op.
- Operation  input  4  op code (encoding below).
- SrcA  input  DATA_WIDTH  operand A (rs1 or PC).
- SrcB  input  DATA_WIDTH  operand B (rs2 or immediate).
- out_valid  output  1  ALUResult/BrTaken valid.
- out_ready  input  1  consumer accepts result.
- ALUResult  output  DATA_WIDTH  registered result.
- BrTaken  output  1  branch condition true (branch ops only, else 0).
- Busy  output  1  state != IDLE.

Behaviour:
- Operation encoding:
  - 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 slt (signed).
  - 0110 sra, 0111 srl, 1000 sll.
  - 1010 bne, 1011 blt (signed), 1100 bge (signed), 1101 beq.
  - 1110 lui: result = SrcB.
  - 1111 jal: result = SrcA + 4.
  - 1001 undefined: result 0, BrTaken 0.
- Branch ops: ALUResult = {0..., cond}; BrTaken = cond.
- Arithmetic wraps modulo 2^DATA_WIDTH. slt/blt/bge compare signed; slt result is 1 or 0.
- Reset (async, reset=0): state IDLE, in_ready=0 while asserted, out_valid=0, ALUResult=0, BrTaken=0, Busy=0, counters 0. Effective mid-shift or mid-hold; any in-flight op is discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid, latch inputs.
    - Non-shift op: compute, register result, go DONE.
    - Shift with shamt=0: result=SrcA, go DONE.
    - Shift with shamt>0: load acc=SrcA, cnt=shamt, go SHIFT.
  - SHIFT: each cycle shift acc by 1 (sll: <<1; srl: >>1 zero-fill; sra: >>1 sign-fill) and decrement cnt. When cnt==1 this cycle, write the final value to ALUResult and go DONE.
  - DONE: out_valid=1. ALUResult/BrTaken held stable until out_ready. On out_ready, go IDLE, out_valid=0 next cycle.
- in_ready is 0 in SHIFT and DONE; in_valid is ignored there. There is no accept in the same cycle as a DONE→IDLE handoff.
- Latency, accept edge N to out_valid high:
  - Non-shift or shamt=0: N+1.
  - Shift by k>0: N+1+k.
  - Throughput for non-shift ops is one op per 2 cycles minimum.
- SrcB bits above SHAMT_WIDTH are ignored for shifts.
- out_ready asserted in states other than DONE has no effect.

Optional Feature:
- Macro ALU_ITER_FAST_SHIFT_EN.
  - Defined: shifts use a single-cycle barrel shifter, the SHIFT state is never entered, and all ops have N+1 latency.
  - Undefined: iterative shifting as above.
- Encoding, handshake and reset behaviour are identical in both builds.

Test Plan:
- Reset low mid-SHIFT (sll by 20, after 5 cycles) → next sample: out_valid=0, Busy=0, ALUResult=0. After release, in_ready=1 and the new op add 1+1 returns 2.
- add 0x7FFFFFFF+1 → ALUResult=0x80000000, out_valid at N+1. sub 3-5 → 0xFFFFFFFE. slt -1,1 → 1.
- sra 0x80000000 by 4 → 0xF8000000 at N+5. srl same → 0x08000000. sll 1 by 31 → 0x80000000 at N+32. sll by 0 with SrcB=0x20 → SrcA unchanged at N+1.
- Branches:
  - beq 5,5 → BrTaken=1, ALUResult=1.
  - bne 5,5 → BrTaken=0.
  - blt -2,1 → 1.
  - bge -2,1 → 0.
  - lui SrcB=0x12345000 → 0x12345000.
  - jal SrcA=0x100 → 0x104.
  - 1001 → 0.
- Backpressure: out_ready held 0 for 6 cycles after xor 0xF0,0xFF → ALUResult=0x0F stable and out_valid=1 throughout. in_valid pulses during the hold are ignored (in_ready=0). Release → IDLE next cycle.
- With ALU_ITER_FAST_SHIFT_EN: sra 0x80000000 by 31 → 0xFFFFFFFF at N+1, Busy never observed in SHIFT.
